// File: rtl/ram1_port.sv
// ram1_port: single-word access engine for the off-chip RAM1 SRAM, sequencing address/data/strobes.
// Define RAM1_PORT_VERIFY_EN to read back every written word and flag mismatches on err.
module ram1_port #(
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [17:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        done,
   output logic [15:0] rdata,
   output logic        err,
   output logic [17:0] Ram1Addr,
   inout  wire  [15:0] Ram1Data,
   output logic        Ram1EN,
   output logic        Ram1OE,
   output logic        Ram1WE
);
   localparam int MAXC = WR_CYCLES > RD_CYCLES ? WR_CYCLES : RD_CYCLES;
   localparam int CW = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS
`ifdef RAM1_PORT_VERIFY_EN
      , VF_ACCESS
`endif
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   wdata_q;
   logic          drive;

   assign req_ready = state == IDLE;
   assign Ram1Data  = drive ? wdata_q : 16'hzzzz;

`ifdef RAM1_PORT_VERIFY_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // strobes are registered alongside the state so they change cleanly on the edge
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         cnt      <= '0;
         wdata_q  <= '0;
         drive    <= 1'b0;
         Ram1Addr <= '0;
         Ram1EN   <= 1'b1;
         Ram1OE   <= 1'b1;
         Ram1WE   <= 1'b1;
         done     <= 1'b0;
         rdata    <= '0;
`ifdef RAM1_PORT_VERIFY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               Ram1Addr <= req_addr;
               wdata_q  <= req_wdata;
               Ram1EN   <= 1'b0;
               Ram1OE   <= req_we;
               drive    <= req_we;
               cnt      <= CW'(RD_CYCLES - 1);
               state    <= req_we ? WR_SETUP : RD_ACCESS;
            end
            WR_SETUP: begin
               Ram1WE <= 1'b0;
               cnt    <= CW'(WR_CYCLES - 1);
               state  <= WR_PULSE;
            end
            WR_PULSE: if (cnt == '0) begin
               Ram1WE <= 1'b1;
               state  <= WR_HOLD;
            end else cnt <= cnt - CW'(1);
            WR_HOLD: begin
               drive <= 1'b0;
`ifdef RAM1_PORT_VERIFY_EN
               Ram1OE <= 1'b0;
               cnt    <= CW'(RD_CYCLES - 1);
               state  <= VF_ACCESS;
`else
               Ram1EN <= 1'b1;
               done   <= 1'b1;
               state  <= IDLE;
`endif
            end
            RD_ACCESS: if (cnt == '0) begin
               rdata  <= Ram1Data;
               Ram1EN <= 1'b1;
               Ram1OE <= 1'b1;
               done   <= 1'b1;
               state  <= IDLE;
            end else cnt <= cnt - CW'(1);
`ifdef RAM1_PORT_VERIFY_EN
            VF_ACCESS: if (cnt == '0) begin
               rdata  <= Ram1Data;
               Ram1EN <= 1'b1;
               Ram1OE <= 1'b1;
               done   <= 1'b1;
               state  <= IDLE;
               if (Ram1Data != wdata_q) err_q <= 1'b1;
            end else cnt <= cnt - CW'(1);
`endif
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram1_port.sv
// tb_ram1_port: scoreboard bench for ram1_port with a behavioural SRAM model on Ram1Data.
module tb_ram1_port;
   localparam int WR = 2;
   localparam int RD = 2;
`ifdef RAM1_PORT_VERIFY_EN
   localparam int WLAT = WR + 3 + RD;
   localparam bit VF = 1'b1;
`else
   localparam int WLAT = WR + 3;
   localparam bit VF = 1'b0;
`endif
   localparam int RLAT = RD + 1;

   logic        CLK = 1'b0, RST = 1'b1, req_valid = 1'b0, req_we = 1'b0;
   logic [17:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        req_ready, done, err, Ram1EN, Ram1OE, Ram1WE;
   logic [15:0] rdata;
   logic [17:0] Ram1Addr;
   wire  [15:0] Ram1Data;

   int checks = 0, errors = 0, edges = 0, wlow = 0, olow = 0;
   logic        prev_we = 1'b1, prev_oe = 1'b1, corrupt_on = 1'b0;
   logic [17:0] last_a = '0;
   logic [15:0] last_wd = '0, last_rd = '0;
   logic [15:0] mem [0:1023];
   logic [15:0] bd [10] = '{16'd7, 16'd9, 16'd8, 16'd6, 16'd4, 16'd5, 16'd1, 16'd2, 16'd0, 16'd3};

   typedef struct {int due; logic [15:0] d;} exp_t;
   exp_t q[$];

   ram1_port #(.WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
      .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data), .Ram1EN(Ram1EN), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE)
   );

   // SRAM model drives the bus while enabled and output-enabled; optional readback corruption at 0x100
   assign Ram1Data = (!Ram1EN && !Ram1OE)
      ? (mem[Ram1Addr[9:0]] ^ ((corrupt_on && Ram1Addr == 18'h00100) ? 16'h0001 : 16'h0000))
      : 16'hzzzz;

   always #5 CLK = ~CLK;
   always @(posedge CLK) edges++;

   initial for (int i = 0; i < 1024; i++) mem[i] = '0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (!RST) begin
         wlow = 0;
         olow = 0;
      end else begin
         if (!Ram1EN) chk("we_oe_overlap", 32'(!Ram1WE && !Ram1OE), 32'd0);
         if (!Ram1EN && Ram1OE) begin
            chk("wr_addr", 32'(Ram1Addr), 32'(last_a));
            chk("wr_data", 32'(Ram1Data), 32'(last_wd));
         end
         if (!Ram1EN && !Ram1OE) chk("rd_addr", 32'(Ram1Addr), 32'(last_a));
         if (!Ram1WE) begin
            wlow++;
            mem[Ram1Addr[9:0]] = Ram1Data;
         end
         if (!Ram1OE) olow++;
         if (Ram1WE && !prev_we) begin
            chk("we_width", 32'(wlow), 32'(WR));
            wlow = 0;
         end
         if (Ram1OE && !prev_oe) begin
            chk("oe_width", 32'(olow), 32'(RD));
            olow = 0;
         end
         if (done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending access (t=%0t)", $time);
            end else begin
               e = q.pop_front();
               chk("done_time", 32'(edges), 32'(e.due));
               chk("rdata", 32'(rdata), 32'(e.d));
            end
         end
      end
      prev_we = Ram1WE;
      prev_oe = Ram1OE;
   end

   task automatic do_req(input logic we, input logic [17:0] a, input logic [15:0] d, input logic b2b);
      exp_t e;
      int n = 0;
      while (!req_ready && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("req_ready", 32'(req_ready), 32'd1);
      if (b2b) chk("b2b_done", 32'(done), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      last_a    = a;
      if (we) begin
         last_wd = d;
         if (VF) last_rd = d ^ ((corrupt_on && a == 18'h00100) ? 16'h0001 : 16'h0000);
         e.due = edges + WLAT;
      end else begin
         last_rd = d;
         e.due = edges + RLAT;
      end
      e.d = last_rd;
      q.push_back(e);
      @(negedge CLK);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #1 RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_en", 32'(Ram1EN), 32'd1);
      chk("rst_oe", 32'(Ram1OE), 32'd1);
      chk("rst_we", 32'(Ram1WE), 32'd1);
      chk("rst_data_z", 32'(Ram1Data === 16'hzzzz), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
      chk("rst_addr", 32'(Ram1Addr), 32'd0);
      RST = 1'b1;
      @(negedge CLK);
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      do_req(1'b1, 18'h000F9, 16'h0007, 1'b0);
      do_req(1'b0, 18'h000F9, 16'h0007, 1'b1);
      for (int i = 0; i < 10; i++) do_req(1'b1, 18'h000F9 + 18'(i), bd[i], 1'b1);
      for (int i = 0; i < 10; i++) do_req(1'b0, 18'h000F9 + 18'(i), bd[i], 1'b1);

      // abort a write while WE is low
      do_req(1'b1, 18'h00080, 16'h1234, 1'b0);
      @(negedge CLK);
      chk("we_low_before_rst", 32'(Ram1WE), 32'd0);
      #2 RST = 1'b0;
      #1;
      chk("rst_mid_we", 32'(Ram1WE), 32'd1);
      chk("rst_mid_en", 32'(Ram1EN), 32'd1);
      chk("rst_mid_data_z", 32'(Ram1Data === 16'hzzzz), 32'd1);
      q.delete(q.size() - 1);
      last_rd = '0;
      repeat (2) @(negedge CLK);
      chk("rst_mid_no_done", 32'(done), 32'd0);
      RST = 1'b1;
      do_req(1'b1, 18'h00050, 16'hBEEF, 1'b0);
      do_req(1'b0, 18'h00050, 16'hBEEF, 1'b1);
      drain();
      chk("err_clean", 32'(err), 32'd0);

`ifdef RAM1_PORT_VERIFY_EN
      corrupt_on = 1'b1;
      do_req(1'b1, 18'h00100, 16'h00A5, 1'b0);
      drain();
      corrupt_on = 1'b0;
      chk("err_set", 32'(err), 32'd1);
      do_req(1'b1, 18'h00060, 16'h0F0F, 1'b0);
      drain();
      chk("err_sticky", 32'(err), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("err_cleared", 32'(err), 32'd0);
      last_rd = '0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
`endif

      chk("err_final", 32'(err), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1, "timeout");
   end
endmodule
